// File: rtl/led_fade_driver.sv
// Per-LED PWM fade stage: turns on/off requests into linear ramps and drives the board pins.
// Optional build macro LED_GAMMA_EN squares the duty before the PWM compare.
`timescale 1ns/1ps
module led_fade_driver #(
  parameter int N_LED        = 4,
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 24,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
`ifdef LED_GAMMA_EN
  localparam int SQ_W = 2 * PWM_BITS;
`endif

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RISE,
    ST_ON,
    ST_FALL
  } fade_state_e;

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic                w_pwm_wrap;
  logic                w_step_tick;

  fade_state_e         r_state     [N_LED];
  fade_state_e         w_state_nxt [N_LED];
  logic [PWM_BITS-1:0] r_duty      [N_LED];
  logic [PWM_BITS-1:0] w_duty_nxt  [N_LED];
  logic [PWM_BITS-1:0] w_eff_duty  [N_LED];
`ifdef LED_GAMMA_EN
  logic [SQ_W-1:0]     w_duty_sq   [N_LED];
`endif

  logic [N_LED-1:0]    w_lit;
  logic [N_LED-1:0]    w_fading;
  logic [N_LED-1:0]    r_led_out;
  logic                r_busy;

  assign w_pwm_wrap  = (r_pwm_cnt == PWM_MAX);
  assign w_step_tick = w_pwm_wrap && (r_step_cnt == STEP_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_step_tick) begin
        r_step_cnt <= '0;
      end else if (w_pwm_wrap) begin
        r_step_cnt <= r_step_cnt + STEP_W'(1);
      end
    end
  end

  // NOTE: hold-value defaults come first so every path assigns both outputs and no latch forms.
  always_comb begin : fsm_next
    for (int i = 0; i < N_LED; i++) begin
      w_state_nxt[i] = r_state[i];
      w_duty_nxt[i]  = r_duty[i];
      unique case (r_state[i])
        ST_OFF: begin
          if (led_in[i]) w_state_nxt[i] = ST_RISE;
        end
        ST_RISE: begin
          // A reversal outranks a coincident step: duty is frozen on that clock.
          if (!led_in[i]) begin
            w_state_nxt[i] = ST_FALL;
          end else if (w_step_tick) begin
            if (r_duty[i] == PWM_MAX) w_state_nxt[i] = ST_ON;
            else                      w_duty_nxt[i]  = r_duty[i] + PWM_BITS'(1);
          end
        end
        ST_ON: begin
          if (!led_in[i]) w_state_nxt[i] = ST_FALL;
        end
        ST_FALL: begin
          if (led_in[i]) begin
            w_state_nxt[i] = ST_RISE;
          end else if (w_step_tick) begin
            if (r_duty[i] == '0) w_state_nxt[i] = ST_OFF;
            else                 w_duty_nxt[i]  = r_duty[i] - PWM_BITS'(1);
          end
        end
      endcase
    end
  end

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LED; i++) begin
        r_state[i] <= ST_OFF;
        r_duty[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_duty[i]  <= w_duty_nxt[i];
      end
    end
  end

  always_comb begin : eff_duty_calc
    for (int i = 0; i < N_LED; i++) begin
`ifdef LED_GAMMA_EN
      w_duty_sq[i]  = SQ_W'(r_duty[i]) * SQ_W'(r_duty[i]);
      w_eff_duty[i] = w_duty_sq[i][SQ_W-1:PWM_BITS];
`else
      w_eff_duty[i] = r_duty[i];
`endif
    end
  end

  // ON drives a solid level; only the ramp states are modulated.
  always_comb begin : lit_calc
    for (int i = 0; i < N_LED; i++) begin
      w_fading[i] = (r_state[i] == ST_RISE) || (r_state[i] == ST_FALL);
      unique case (r_state[i])
        ST_OFF:  w_lit[i] = 1'b0;
        ST_ON:   w_lit[i] = 1'b1;
        default: w_lit[i] = (r_pwm_cnt < w_eff_duty[i]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_out <= {N_LED{ACTIVE_LOW}};
      r_busy    <= 1'b0;
    end else begin
      r_led_out <= w_lit ^ {N_LED{ACTIVE_LOW}};
      r_busy    <= |w_fading;
    end
  end

  assign led_out = r_led_out;
  assign busy    = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver (N_LED=4, PWM_BITS=4, STEP_PERIODS=2: period 16 clk, step 32 clk).
// Expected levels and per-period lit counts are queued by the stimulus and consumed by a monitor.
`timescale 1ns/1ps
`ifdef LED_GAMMA_EN
`define TB_SEL(lin, gam) (gam)
`else
`define TB_SEL(lin, gam) (lin)
`endif
module tb_led_fade_driver;

  typedef enum logic {K_LEVEL, K_COUNT} kind_e;
  typedef struct {
    int         t;
    kind_e      kind;
    logic [3:0] mask;
    logic [3:0] exp_led;
    logic       exp_busy;
    int         exp_cnt;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led_in = 4'hF;
  logic [3:0] led_out;
  logic       busy;

  int tcyc   = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int cnt_left = 0;
  int cnt_acc  = 0;
  exp_t cur;

  led_fade_driver #(
    .N_LED       (4),
    .PWM_BITS    (4),
    .STEP_PERIODS(2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led_in (led_in),
    .led_out(led_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, tcyc, act, exp);
    end
  endtask

  task automatic push_level(input int t, input logic [3:0] led, input logic bsy, input string name);
    exp_t e;
    e.t = t; e.kind = K_LEVEL; e.mask = 4'h0; e.exp_led = led;
    e.exp_busy = bsy; e.exp_cnt = 0; e.name = name;
    sb_q.push_back(e);
  endtask

  // Counts, over 16 samples starting at cycle t, how often every masked pin is lit (low).
  task automatic push_count(input int t, input logic [3:0] mask, input int cnt, input string name);
    exp_t e;
    e.t = t; e.kind = K_COUNT; e.mask = mask; e.exp_led = 4'h0;
    e.exp_busy = 1'b0; e.exp_cnt = cnt; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic goto(input int t);
    while (tcyc < t) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t item;
    forever begin
      @(negedge clk);
      if (cnt_left > 0) begin
        if ((led_out & cur.mask) == 4'h0) cnt_acc++;
        cnt_left--;
        if (cnt_left == 0) check(cur.name, cnt_acc, cur.exp_cnt);
      end
      while (sb_q.size() > 0 && sb_q[0].t <= tcyc) begin
        item = sb_q.pop_front();
        if (item.t < tcyc) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s: not sampled at cyc %0d (now %0d)", item.name, item.t, tcyc);
        end else if (item.kind == K_LEVEL) begin
          check({item.name, ".led_out"}, led_out, item.exp_led);
          check({item.name, ".busy"}, busy, item.exp_busy);
        end else begin
          cur      = item;
          cnt_acc  = ((led_out & item.mask) == 4'h0) ? 1 : 0;
          cnt_left = 15;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int r;
    // Held in reset with every request on: pins dark, not busy.
    push_level(2, 4'hF, 1'b0, "rst_hold_a");
    push_level(4, 4'hF, 1'b0, "rst_hold_b");
    goto(5);
    led_in = 4'b0001;

    // Full ch0 rise to ON. Edge k after release sits at tcyc r+k; step ticks at k = 32*j.
    r = 6;
    goto(r);
    push_level(r + 1,   4'hF, 1'b0, "rise_first_edge");
    push_level(r + 2,   4'hF, 1'b1, "rise_busy_on");
    push_count(r + 33,  4'h1, `TB_SEL(1, 0),   "rise_duty1");
    push_count(r + 257, 4'h1, `TB_SEL(8, 4),   "rise_duty8");
    push_count(r + 481, 4'h1, `TB_SEL(15, 14), "rise_duty15");
    push_level(r + 512, 4'hF, 1'b1, "rise_last_gap");
    push_level(r + 513, 4'hE, 1'b0, "on_reached");
    push_count(r + 514, 4'h1, 16, "on_solid");
    rst_n = 1'b1;
    goto(r + 530);

    // All channels ramping, then async reset pulse mid-ramp.
    rst_n  = 1'b0;
    led_in = 4'hF;
    r = tcyc + 3;
    goto(r);
    push_level(r + 97,  `TB_SEL(4'h0, 4'hF), 1'b1, "all_ramp_lit");
    push_level(r + 98,  4'hF, 1'b0, "async_rst");
    push_level(r + 99,  4'hF, 1'b0, "rst_pulse_a");
    push_level(r + 101, 4'hF, 1'b0, "rst_pulse_b");
    push_level(r + 102, 4'hF, 1'b0, "rerelease_edge1");
    push_level(r + 103, 4'hF, 1'b1, "rerelease_busy");
    push_count(r + 118, 4'hF, 0, "rerelease_duty0");
    push_count(r + 134, 4'hF, `TB_SEL(1, 0), "rerelease_duty1");
    rst_n = 1'b1;
    goto(r + 97);
    @(posedge clk);
    #2 rst_n = 1'b0;
    goto(r + 101);
    rst_n = 1'b1;
    goto(r + 151);

    // ch0 rises for 5 ticks, then falls back to OFF.
    rst_n  = 1'b0;
    led_in = 4'b0001;
    r = tcyc + 3;
    goto(r);
    push_count(r + 145, 4'h1, `TB_SEL(4, 1), "pre_drop_duty4");
    push_count(r + 177, 4'h1, `TB_SEL(5, 1), "fall_duty5");
    push_count(r + 193, 4'h1, `TB_SEL(4, 1), "fall_duty4");
    push_count(r + 321, 4'h1, 0, "fall_duty0_dark");
    push_level(r + 352, 4'hF, 1'b1, "fall_last");
    push_level(r + 353, 4'hF, 1'b0, "fall_off");
    rst_n = 1'b1;
    goto(r + 160);
    led_in[0] = 1'b0;
    goto(r + 360);

    // ch1: reversal coinciding with a tick keeps duty; ch2: pulse spanning one tick.
    rst_n  = 1'b0;
    led_in = 4'b0010;
    r = tcyc + 3;
    goto(r);
    push_count(r + 129, 4'h2, `TB_SEL(3, 0), "rev_on_tick_duty3");
    push_count(r + 177, 4'h4, `TB_SEL(1, 0), "short_pulse_duty1");
    push_level(r + 225, 4'hD, 1'b1, "ch1_rise_ch2_off");
    rst_n = 1'b1;
    goto(r + 96);
    led_in[1] = 1'b0;
    goto(r + 127);
    led_in[1] = 1'b1;
    goto(r + 149);
    led_in[2] = 1'b1;
    goto(r + 169);
    led_in[2] = 1'b0;
    goto(r + 240);

    for (int i = 0; i < 64 && (sb_q.size() > 0 || cnt_left > 0); i++) @(negedge clk);
    while (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: never sampled", sb_q[0].name);
      void'(sb_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
